bits_to_bytes_stream: RTL and testbench

BITS_TO_BYTES_STREAM -- requirements
Module: bits_to_bytes_stream

---
 rtl/bits_to_bytes_stream.sv | 92 +++++++++
 tb/tb_bits_to_bytes_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bits_to_bytes_stream.sv
// Packs a little-endian bit stream of IN_W-bit beats into OUT_BYTES-byte words.
// Optional BTB_PAD_ERR_EN adds a pad_err pulse when a message ends mid-byte.
module bits_to_bytes_stream #(
  parameter int IN_W      = 1,
  parameter int OUT_BYTES = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_W-1:0]                    in_bits,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [8*OUT_BYTES-1:0]             out_data,
  output logic                               out_last,
  output logic [$clog2(OUT_BYTES+1)-1:0]     out_nbytes
`ifdef BTB_PAD_ERR_EN
  ,
  output logic                               pad_err
`endif
);

  localparam int W     = 8 * OUT_BYTES;
  localparam int CNT_W = $clog2(W + 1);
  localparam int NB_W  = $clog2(OUT_BYTES + 1);
  localparam logic [CNT_W:0] ROUND_UP = 7;

  logic [W-1:0]     acc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] fill;
  logic [W-1:0]     merged;
  logic             accept;
  logic             complete;

  // Bytes touched by nbits stream bits, i.e. ceil(nbits/8).
  function automatic logic [NB_W-1:0] bytes_used(input logic [CNT_W-1:0] nbits);
    logic [CNT_W:0] rounded;
    rounded = {1'b0, nbits} + ROUND_UP;
    return NB_W'(rounded >> 3);
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign fill     = cnt_p0 + CNT_W'(IN_W);
  assign merged   = acc_p0 | (W'(in_bits) << cnt_p0);
  assign complete = accept && (in_last || fill == CNT_W'(W));

  // Stage p0: accumulator; cleared on completion so padding reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
    end else if (accept) begin
      if (complete) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        acc_p0 <= merged;
        cnt_p0 <= fill;
      end
    end
  end

  // Stage p1: output holding register, reloads back-to-back when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_nbytes <= '0;
    end else if (complete) begin
      out_valid  <= 1'b1;
      out_data   <= merged;
      out_last   <= in_last;
      out_nbytes <= bytes_used(fill);
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef BTB_PAD_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_err <= 1'b0;
    end else begin
      pad_err <= accept && in_last && (fill[2:0] != 3'd0);
    end
  end
`endif

endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// Self-checking bench for bits_to_bytes_stream: directed scenarios on five
// parameterisations plus randomized traffic scored against a bit-queue model.
module tb_bits_to_bytes_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic iv[5], il[5], ordy[5], irdy[5], ov[5], ol[5];
  logic [0:0]  ib0;
  logic [7:0]  ib1;
  logic [3:0]  ib2;
  logic [7:0]  ib3;
  logic [1:0]  ib4;
  logic [7:0]  od0, od3, od4;
  logic [31:0] od1;
  logic [15:0] od2;
  logic        nb0, nb3, nb4;
  logic [2:0]  nb1;
  logic [1:0]  nb2;
`ifdef BTB_PAD_ERR_EN
  logic pe[5];
`endif

  int INW[5] = '{1, 8, 4, 8, 2};
  int WB[5]  = '{8, 32, 16, 8, 8};

  bits_to_bytes_stream #(.IN_W(1), .OUT_BYTES(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_bits(ib0),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
    .out_last(ol[0]), .out_nbytes(nb0)
`ifdef BTB_PAD_ERR_EN
    , .pad_err(pe[0])
`endif
  );
  bits_to_bytes_stream #(.IN_W(8), .OUT_BYTES(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_bits(ib1),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
    .out_last(ol[1]), .out_nbytes(nb1)
`ifdef BTB_PAD_ERR_EN
    , .pad_err(pe[1])
`endif
  );
  bits_to_bytes_stream #(.IN_W(4), .OUT_BYTES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_bits(ib2),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2),
    .out_last(ol[2]), .out_nbytes(nb2)
`ifdef BTB_PAD_ERR_EN
    , .pad_err(pe[2])
`endif
  );
  bits_to_bytes_stream #(.IN_W(8), .OUT_BYTES(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]), .in_bits(ib3),
    .in_last(il[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od3),
    .out_last(ol[3]), .out_nbytes(nb3)
`ifdef BTB_PAD_ERR_EN
    , .pad_err(pe[3])
`endif
  );
  bits_to_bytes_stream #(.IN_W(2), .OUT_BYTES(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(irdy[4]), .in_bits(ib4),
    .in_last(il[4]), .out_valid(ov[4]), .out_ready(ordy[4]), .out_data(od4),
    .out_last(ol[4]), .out_nbytes(nb4)
`ifdef BTB_PAD_ERR_EN
    , .pad_err(pe[4])
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: stream bits of the open message, and the words owed downstream.
  bit          mb[$];
  logic [31:0] e_data[$];
  int          e_nb[$];
  logic        e_last[$];

  function automatic logic [31:0] get_od(input int i);
    case (i)
      0: return {24'd0, od0};
      1: return od1;
      2: return {16'd0, od2};
      3: return {24'd0, od3};
      default: return {24'd0, od4};
    endcase
  endfunction

  function automatic logic [31:0] get_nb(input int i);
    case (i)
      0: return {31'd0, nb0};
      1: return {29'd0, nb1};
      2: return {30'd0, nb2};
      3: return {31'd0, nb3};
      default: return {31'd0, nb4};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input int i, input logic [7:0] b, input logic l);
    logic [31:0] d;
    for (int k = 0; k < INW[i]; k++) mb.push_back(b[k]);
    if (mb.size() == WB[i] || l) begin
      d = '0;
      for (int k = 0; k < mb.size(); k++) d[k] = mb[k];
      e_data.push_back(d);
      e_nb.push_back((mb.size() + 7) / 8);
      e_last.push_back(l);
      mb.delete();
    end
  endtask

  // Drive one cycle on instance i (from a negedge), score any word consumed at
  // the coming edge, update the model, and return at the next negedge.
  task automatic cycle(input int i, input logic v, input logic [7:0] b,
                       input logic l, input logic r, output logic a);
    iv[i] = v; il[i] = l; ordy[i] = r;
    case (i)
      0: ib0 = b[0:0];
      1: ib1 = b;
      2: ib2 = b[3:0];
      3: ib3 = b;
      default: ib4 = b[1:0];
    endcase
    #1;
    if (ov[i] && r) begin
      if (e_data.size() == 0) begin
        chk("unexpected_word", {31'd0, ov[i]}, 32'd0);
      end else begin
        chk("word_data", get_od(i), e_data.pop_front());
        chk("word_nbytes", get_nb(i), e_nb.pop_front());
        chk("word_last", {31'd0, ol[i]}, {31'd0, e_last.pop_front()});
      end
    end
    a = v && irdy[i];
    if (a) model_beat(i, b, l);
    @(negedge clk);
    iv[i] = 1'b0;
    il[i] = 1'b0;
  endtask

  logic a;
  int   idx;
  logic [7:0] bytes4[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] nib[3]    = '{8'h0B, 8'h0A, 8'h03};
  logic [7:0] bits8;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b1;
    end
    ib0 = '0; ib1 = '0; ib2 = '0; ib3 = '0; ib4 = '0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_out_valid", {31'd0, ov[i]}, 32'd0);
      chk("rst_out_data", get_od(i), 32'd0);
      chk("rst_out_nbytes", get_nb(i), 32'd0);
      chk("rst_out_last", {31'd0, ol[i]}, 32'd0);
      chk("rst_in_ready", {31'd0, irdy[i]}, 32'd1);
`ifdef BTB_PAD_ERR_EN
      chk("rst_pad_err", {31'd0, pe[i]}, 32'd0);
`endif
    end
    rst = 1'b0;
    @(negedge clk);

    // Bit order: 1 followed by seven zeros, last on the eighth
    bits8 = 8'b0000_0001;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1'b1, {7'd0, bits8[k]}, k == 7, 1'b0, a);
      if (k == 6) chk("t1_no_early_word", {31'd0, ov[0]}, 32'd0);
    end
    chk("t1_valid", {31'd0, ov[0]}, 32'd1);
    chk("t1_data", get_od(0), 32'h01);
    chk("t1_nbytes", get_nb(0), 32'd1);
    chk("t1_last", {31'd0, ol[0]}, 32'd1);
    cycle(0, 1'b0, 8'd0, 1'b0, 1'b1, a);

    // Word packing, two consecutive words with no bubble
    for (int k = 0; k < 8; k++) begin
      cycle(1, 1'b1, 8'(k + 1), 1'b0, 1'b1, a);
      chk("t2_beat_taken", {31'd0, a}, 32'd1);
      if (k == 3) begin
        chk("t2_w0_valid", {31'd0, ov[1]}, 32'd1);
        chk("t2_w0_data", get_od(1), 32'h04030201);
        chk("t2_w0_nbytes", get_nb(1), 32'd4);
        chk("t2_w0_last", {31'd0, ol[1]}, 32'd0);
      end
    end
    chk("t2_w1_valid", {31'd0, ov[1]}, 32'd1);
    chk("t2_w1_data", get_od(1), 32'h08070605);
    cycle(1, 1'b0, 8'd0, 1'b0, 1'b1, a);

    // Padding: nibbles B, A, 3 with last
    for (int k = 0; k < 3; k++) cycle(2, 1'b1, nib[k], k == 2, 1'b0, a);
    chk("t3_valid", {31'd0, ov[2]}, 32'd1);
    chk("t3_data", get_od(2), 32'h03AB);
    chk("t3_nbytes", get_nb(2), 32'd2);
    chk("t3_last", {31'd0, ol[2]}, 32'd1);
`ifdef BTB_PAD_ERR_EN
    chk("t3_pad_err_hi", {31'd0, pe[2]}, 32'd1);
`endif
    cycle(2, 1'b0, 8'd0, 1'b0, 1'b1, a);
`ifdef BTB_PAD_ERR_EN
    chk("t3_pad_err_lo", {31'd0, pe[2]}, 32'd0);
`endif

    // Backpressure: first word held for five cycles, then drained in order
    cycle(3, 1'b1, bytes4[0], 1'b0, 1'b0, a);
    chk("t4_first_taken", {31'd0, a}, 32'd1);
    for (int h = 0; h < 5; h++) begin
      cycle(3, 1'b1, bytes4[1], 1'b0, 1'b0, a);
      chk("t4_hold_blocked", {31'd0, a}, 32'd0);
      chk("t4_hold_in_ready", {31'd0, irdy[3]}, 32'd0);
      chk("t4_hold_data", get_od(3), 32'hA1);
      chk("t4_hold_valid", {31'd0, ov[3]}, 32'd1);
    end
    idx = 1;
    for (int g = 0; g < 20 && idx < 4; g++) begin
      cycle(3, 1'b1, bytes4[idx], 1'b0, 1'b1, a);
      if (a) idx++;
    end
    chk("t4_all_fed", idx, 32'd4);
    for (int g = 0; g < 3; g++) cycle(3, 1'b0, 8'd0, 1'b0, 1'b1, a);
    chk("t4_drained", e_data.size(), 32'd0);

    // Reset mid-word discards the partial accumulator
    for (int k = 0; k < 3; k++) cycle(4, 1'b1, 8'($urandom_range(0, 3)), 1'b0, 1'b1, a);
    chk("t5_no_word_yet", {31'd0, ov[4]}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, ov[4]}, 32'd0);
    chk("t5_rst_data", get_od(4), 32'd0);
    chk("t5_rst_in_ready", {31'd0, irdy[4]}, 32'd1);
    #1 rst = 1'b0;
    mb.delete();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      cycle(4, 1'b1, 8'h01, 1'b0, 1'b0, a);
      if (k == 2) chk("t5_no_stale_word", {31'd0, ov[4]}, 32'd0);
    end
    chk("t5_valid", {31'd0, ov[4]}, 32'd1);
    chk("t5_data", get_od(4), 32'h55);
    chk("t5_nbytes", get_nb(4), 32'd1);
    chk("t5_last", {31'd0, ol[4]}, 32'd0);
    cycle(4, 1'b0, 8'd0, 1'b0, 1'b1, a);

    // Randomized traffic against the model on the two multi-byte builds
    for (int s = 1; s <= 2; s++) begin
      mb.delete();
      for (int n = 0; n < 300; n++)
        cycle(s, ($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0, ($urandom % 4) != 0, a);
      a = 1'b0;
      for (int g = 0; g < 20 && !a; g++) cycle(s, 1'b1, 8'($urandom), 1'b1, 1'b1, a);
      chk("rand_flush_taken", {31'd0, a}, 32'd1);
      for (int g = 0; g < 4; g++) cycle(s, 1'b0, 8'd0, 1'b0, 1'b1, a);
      chk("rand_drained", e_data.size(), 32'd0);
      chk("rand_idle_valid", {31'd0, ov[s]}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
